// File: rtl/i2c_tick_scheduler_pkg.sv
// Shared types and defaults for the I2C tick scheduler and its divider.
// Run-state encoding plus the reset-time divider threshold.
package i2c_tick_scheduler_pkg;

    localparam int          DIV_W_DEF     = 24;
    localparam int          CNT_W_DEF     = 8;
    localparam logic [23:0] RESET_THR_DEF = 24'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/i2c_tick_divider.sv
// Quarter-period divider: counts enabled cycles and strobes o_tick when the
// count reaches the active threshold, then restarts from zero.
module i2c_tick_divider
    import i2c_tick_scheduler_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [DIV_W-1:0] i_thr,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_count;
    logic [DIV_W-1:0] w_count_next;

    assign o_tick = i_en && (r_count == i_thr);

    always_comb begin
        w_count_next = r_count;
        if (i_clr) begin
            w_count_next = '0;
        end else if (i_en) begin
            w_count_next = o_tick ? '0 : r_count + DIV_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

endmodule

// File: rtl/i2c_tick_scheduler.sv
// Enable-strobe scheduler for the I2C FSM: four phase strobes per bit period,
// a bit counter for the requested run length, and a shadowed divider threshold.
module i2c_tick_scheduler
    import i2c_tick_scheduler_pkg::*;
#(
    parameter int               DIV_W     = DIV_W_DEF,
    parameter int               CNT_W     = CNT_W_DEF,
    parameter logic [DIV_W-1:0] RESET_THR = DIV_W'(RESET_THR_DEF)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_cfg_valid,
    output logic             o_cfg_ready,
    input  logic [DIV_W-1:0] i_cfg_threshold,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_nbits,
    input  logic             i_abort,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_phase_tick,
    output logic [1:0]       o_phase,
    output logic             o_bit_tick,
    output logic [CNT_W-1:0] o_bit_index
);

    sched_state_t     r_state;
    sched_state_t     w_state_next;

    logic [1:0]       r_phase;
    logic [CNT_W-1:0] r_bit_index;
    logic [CNT_W-1:0] r_nbits;
    logic [DIV_W-1:0] r_active_thr;
    logic [DIV_W-1:0] r_shadow_thr;
    logic             r_shadow_full;

    logic             w_idle;
    logic             w_run;
    logic             w_start_acc;
    logic             w_phase_tick;
    logic             w_bit_tick;
    logic             w_last_bit;
    logic             w_cfg_acc;
    logic             w_cfg_direct;
    logic             w_copy;
    logic             w_div_clr;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_run       = (r_state == ST_RUN);
    assign w_start_acc = w_idle && i_start;
    assign w_div_clr   = !w_run || i_abort;

    i2c_tick_divider #(
        .DIV_W (DIV_W)
    ) u_divider (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (w_run),
        .i_clr   (w_div_clr),
        .i_thr   (r_active_thr),
        .o_tick  (w_phase_tick)
    );

    assign w_bit_tick = w_phase_tick && (r_phase == 2'd3);
    assign w_last_bit = w_bit_tick && ((r_bit_index + CNT_W'(1)) == r_nbits);

    // A config arriving in an IDLE cycle that does not launch a run goes
    // straight to the active threshold; otherwise it parks in the shadow.
    assign w_cfg_acc    = i_cfg_valid && !r_shadow_full;
    assign w_cfg_direct = w_cfg_acc && w_idle && !i_start;
    assign w_copy       = r_shadow_full && ((w_idle && !i_start) || (w_run && w_bit_tick));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next = (i_nbits == '0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                o_busy = 1'b1;
                if (i_abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_last_bit) begin
                    w_state_next = ST_FIN;
                end
            end
            ST_FIN: begin
                o_done       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_phase     <= 2'd0;
            r_bit_index <= '0;
            r_nbits     <= '0;
        end else begin
            if (w_div_clr) begin
                r_phase <= 2'd0;
            end else if (w_phase_tick) begin
                r_phase <= r_phase + 2'd1;
            end

            if (w_start_acc || (i_abort && !w_idle)) begin
                r_bit_index <= '0;
            end else if (w_run && w_bit_tick) begin
                r_bit_index <= r_bit_index + CNT_W'(1);
            end

            if (w_start_acc) begin
                r_nbits <= i_nbits;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_active_thr  <= RESET_THR;
            r_shadow_thr  <= '0;
            r_shadow_full <= 1'b0;
        end else begin
            if (w_copy) begin
                r_active_thr <= r_shadow_thr;
            end else if (w_cfg_direct) begin
                r_active_thr <= i_cfg_threshold;
            end

            if (w_copy) begin
                r_shadow_full <= 1'b0;
            end else if (w_cfg_acc && !w_cfg_direct) begin
                r_shadow_full <= 1'b1;
            end

            if (w_cfg_acc && !w_cfg_direct) begin
                r_shadow_thr <= i_cfg_threshold;
            end
        end
    end

    assign o_cfg_ready  = !r_shadow_full;
    assign o_phase_tick = w_phase_tick;
    assign o_phase      = r_phase;
    assign o_bit_tick   = w_bit_tick;
    assign o_bit_index  = r_bit_index;

endmodule

// File: tb/tb_i2c_tick_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a timeline model of phase/bit strobes derived from run start.
module tb_i2c_tick_scheduler;

    localparam int DIV_W = 24;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [DIV_W-1:0] cfg_threshold;
    logic             start;
    logic [CNT_W-1:0] nbits;
    logic             abort;
    logic             busy;
    logic             done;
    logic             phase_tick;
    logic [1:0]       phase;
    logic             bit_tick;
    logic [CNT_W-1:0] bit_index;

    i2c_tick_scheduler dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_cfg_valid     (cfg_valid),
        .o_cfg_ready     (cfg_ready),
        .i_cfg_threshold (cfg_threshold),
        .i_start         (start),
        .i_nbits         (nbits),
        .i_abort         (abort),
        .o_busy          (busy),
        .o_done          (done),
        .o_phase_tick    (phase_tick),
        .o_phase         (phase),
        .o_bit_tick      (bit_tick),
        .o_bit_index     (bit_index)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    longint cyc    = 0;

    // Model: mode 0 idle, 1 running, 2 finishing. Strobes come from the
    // offset into the current bit and that bit's threshold.
    int     m_mode;
    longint m_bit_start;
    longint m_bit_thr;
    longint m_active;
    longint m_shadow;
    bit     m_full;
    longint m_nbits;
    longint m_bits;

    longint q_ptick[$];
    longint q_btick[$];
    longint q_done[$];

    function automatic void chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic longint qat(input longint q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    function automatic void model_reset();
        m_mode      = 0;
        m_bit_start = 0;
        m_bit_thr   = 9;
        m_active    = 9;
        m_shadow    = 0;
        m_full      = 1'b0;
        m_nbits     = 0;
        m_bits      = 0;
    endfunction

    function automatic longint exp_phase();
        if (m_mode != 1) return 0;
        return (cyc - m_bit_start) / (m_bit_thr + 1);
    endfunction

    function automatic bit exp_ptick();
        if (m_mode != 1) return 1'b0;
        return ((cyc - m_bit_start) % (m_bit_thr + 1)) == m_bit_thr;
    endfunction

    function automatic bit exp_btick();
        return exp_ptick() && (exp_phase() == 3);
    endfunction

    task automatic check_outputs();
        chk("busy", longint'(busy), longint'(m_mode == 1));
        chk("done", longint'(done), longint'(m_mode == 2));
        chk("cfg_ready", longint'(cfg_ready), longint'(!m_full));
        chk("phase_tick", longint'(phase_tick), longint'(exp_ptick()));
        chk("phase", longint'(phase), exp_phase());
        chk("bit_tick", longint'(bit_tick), longint'(exp_btick()));
        chk("bit_index", longint'(bit_index), m_bits);
        if (phase_tick) q_ptick.push_back(cyc);
        if (bit_tick)   q_btick.push_back(cyc);
        if (done)       q_done.push_back(cyc);
    endtask

    task automatic model_step(input bit cv, input longint ct, input bit st,
                              input longint nb, input bit ab);
        bit btick;
        bit acc;
        btick = exp_btick();
        acc   = cv && !m_full;
        case (m_mode)
            0: begin
                if (st) begin
                    m_bits = 0;
                    if (nb == 0) begin
                        m_mode = 2;
                    end else begin
                        m_mode      = 1;
                        m_nbits     = nb;
                        m_bit_start = cyc + 1;
                        m_bit_thr   = m_active;
                    end
                end
                if (m_full && !st) begin
                    m_active = m_shadow;
                    m_full   = 1'b0;
                end else if (acc && !st) begin
                    m_active = ct;
                end else if (acc) begin
                    m_shadow = ct;
                    m_full   = 1'b1;
                end
            end
            1: begin
                if (m_full && btick) begin
                    m_active = m_shadow;
                    m_full   = 1'b0;
                end else if (acc) begin
                    m_shadow = ct;
                    m_full   = 1'b1;
                end
                if (ab) begin
                    m_mode = 0;
                    m_bits = 0;
                end else if (btick) begin
                    m_bits++;
                    if (m_bits == m_nbits) begin
                        m_mode = 2;
                    end else begin
                        m_bit_start = cyc + 1;
                        m_bit_thr   = m_active;
                    end
                end
            end
            default: begin
                if (acc) begin
                    m_shadow = ct;
                    m_full   = 1'b1;
                end
                if (ab) m_bits = 0;
                m_mode = 0;
            end
        endcase
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic cycle(input bit cv, input longint ct, input bit st,
                         input longint nb, input bit ab);
        cfg_valid     = cv;
        cfg_threshold = DIV_W'(ct);
        start         = st;
        nbits         = CNT_W'(nb);
        abort         = ab;
        #1;
        check_outputs();
        model_step(cv, ct, st, nb, ab);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic clear_q();
        q_ptick.delete();
        q_btick.delete();
        q_done.delete();
    endtask

    initial begin
        longint t;
        cfg_valid     = 1'b0;
        cfg_threshold = '0;
        start         = 1'b0;
        nbits         = '0;
        abort         = 1'b0;
        rst           = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_cfg_ready", longint'(cfg_ready), 1);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_phase_tick", longint'(phase_tick), 0);
        chk("rst_bit_index", longint'(bit_index), 0);
        @(negedge clk);
        rst = 1'b0;

        // Default threshold 9, two bits.
        clear_q();
        t = cyc;
        cycle(1'b0, 0, 1'b1, 2, 1'b0);
        idle(89);
        chk("t1_nptick", q_ptick.size(), 8);
        chk("t1_ptick0", qat(q_ptick, 0) - t, 10);
        chk("t1_ptick1", qat(q_ptick, 1) - t, 20);
        chk("t1_btick0", qat(q_btick, 0) - t, 40);
        chk("t1_btick1", qat(q_btick, 1) - t, 80);
        chk("t1_done", qat(q_done, 0) - t, 81);

        // Threshold 0 loaded in IDLE, single bit.
        cycle(1'b1, 0, 1'b0, 0, 1'b0);
        chk("t2_ready_after_cfg", longint'(cfg_ready), 1);
        clear_q();
        t = cyc;
        cycle(1'b0, 0, 1'b1, 1, 1'b0);
        idle(8);
        chk("t2_nptick", q_ptick.size(), 4);
        chk("t2_ptick0", qat(q_ptick, 0) - t, 1);
        chk("t2_ptick3", qat(q_ptick, 3) - t, 4);
        chk("t2_btick0", qat(q_btick, 0) - t, 4);
        chk("t2_done", qat(q_done, 0) - t, 5);

        // Threshold 9, three bits, threshold 4 offered mid first bit.
        cycle(1'b1, 9, 1'b0, 0, 1'b0);
        clear_q();
        t = cyc;
        cycle(1'b0, 0, 1'b1, 3, 1'b0);
        idle(14);
        cycle(1'b1, 4, 1'b0, 0, 1'b0);
        idle(4);
        chk("t3_ready_low", longint'(cfg_ready), 0);
        idle(21);
        chk("t3_ready_high", longint'(cfg_ready), 1);
        idle(45);
        chk("t3_btick0", qat(q_btick, 0) - t, 40);
        chk("t3_btick1", qat(q_btick, 1) - t, 60);
        chk("t3_btick2", qat(q_btick, 2) - t, 80);
        chk("t3_done", qat(q_done, 0) - t, 81);

        // Abort on the second bit tick of a five-bit run (threshold 4).
        clear_q();
        t = cyc;
        cycle(1'b0, 0, 1'b1, 5, 1'b0);
        idle(39);
        chk("t4_bit_tick_at_abort", longint'(bit_tick), 1);
        cycle(1'b0, 0, 1'b0, 0, 1'b1);
        chk("t4_busy_after_abort", longint'(busy), 0);
        chk("t4_index_after_abort", longint'(bit_index), 0);
        idle(1);
        cycle(1'b0, 0, 1'b1, 1, 1'b0);
        idle(22);
        chk("t4_ndone", q_done.size(), 1);
        chk("t4_done", qat(q_done, 0) - t, 63);

        // Zero-length run, then a start pulsed while busy.
        clear_q();
        t = cyc;
        cycle(1'b0, 0, 1'b1, 0, 1'b0);
        idle(3);
        chk("t5_done_zero", qat(q_done, 0) - t, 1);
        chk("t5_nptick_zero", q_ptick.size(), 0);
        clear_q();
        t = cyc;
        cycle(1'b0, 0, 1'b1, 2, 1'b0);
        idle(4);
        cycle(1'b0, 0, 1'b1, 7, 1'b0);
        idle(45);
        chk("t5_done_busy_start", qat(q_done, 0) - t, 41);
        chk("t5_index_final", longint'(bit_index), 2);

        // Asynchronous reset mid-phase with a pending shadow value.
        cycle(1'b0, 0, 1'b1, 3, 1'b0);
        idle(5);
        cycle(1'b1, 2, 1'b0, 0, 1'b0);
        idle(3);
        chk("t6_ready_before_rst", longint'(cfg_ready), 0);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", longint'(busy), 0);
        chk("t6_rst_ready", longint'(cfg_ready), 1);
        chk("t6_rst_phase", longint'(phase), 0);
        chk("t6_rst_index", longint'(bit_index), 0);
        chk("t6_rst_done", longint'(done), 0);
        chk("t6_rst_ptick", longint'(phase_tick), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_q();
        t = cyc;
        cycle(1'b0, 0, 1'b1, 1, 1'b0);
        idle(45);
        chk("t6_ptick0_thr9", qat(q_ptick, 0) - t, 10);
        chk("t6_done", qat(q_done, 0) - t, 41);

        // Random traffic against the model.
        repeat (4000) begin
            cycle($urandom_range(0, 7) == 0, longint'($urandom_range(0, 6)),
                  $urandom_range(0, 5) == 0, longint'($urandom_range(0, 3)),
                  $urandom_range(0, 59) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
